arp_rx_parser: RTL and testbench

Byte-serial ARP receive parser in the TOE receive path. It sits between the Ethernet RX byte stream and the IP-to-MAC cache. It validates Ethernet/ARP headers, extracts the sender protocol address (IP) and sender hardware address (MAC), and issues a one-cycle write into the cache (`ip_o`/`mac_o`/`wea`). It also flags ARP requests so the TX side can build replies and keeps learn/drop statistics.

---
 rtl/arp_rx_parser_pkg.sv | 53 +++++
 rtl/arp_rx_parser_if.sv | 10 +
 rtl/arp_rx_parser_stat_counter.sv | 24 ++
 rtl/arp_rx_parser.sv | 158 +++++++++++++++
 tb/tb_arp_rx_parser.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arp_rx_parser_pkg.sv
// Shared constants for the ARP receive parser: protocol field values,
// byte offsets within an Ethernet+ARP frame, FSM state encoding, and a
// helper that checks one fixed header byte against its expected value.
package toe_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REP   = 16'h0002;

  // Byte offsets counted from the first destination-MAC byte.
  localparam int ARP_OFF_ETYPE = 12;
  localparam int ARP_OFF_HTYPE = 14;
  localparam int ARP_OFF_PTYPE = 16;
  localparam int ARP_OFF_HLEN  = 18;
  localparam int ARP_OFF_PLEN  = 19;
  localparam int ARP_OFF_OPER  = 20;
  localparam int ARP_OFF_SHA   = 22;
  localparam int ARP_OFF_SPA   = 28;
  localparam int ARP_OFF_TPA   = 38;
  localparam int ARP_MIN_LEN   = 42;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DROP   = 2'd2
  } arp_state_e;

  // True when byte b at position idx matches the fixed header, or when
  // idx is not a checked position.
  function automatic logic hdr_byte_ok(input logic [5:0] idx, input logic [7:0] b);
    logic ok;
    ok = 1'b1;
    case (idx)
      6'(ARP_OFF_ETYPE):     ok = (b == ETHERTYPE_ARP[15:8]);
      6'(ARP_OFF_ETYPE + 1): ok = (b == ETHERTYPE_ARP[7:0]);
      6'(ARP_OFF_HTYPE):     ok = (b == ARP_HTYPE_ETH[15:8]);
      6'(ARP_OFF_HTYPE + 1): ok = (b == ARP_HTYPE_ETH[7:0]);
      6'(ARP_OFF_PTYPE):     ok = (b == ARP_PTYPE_IPV4[15:8]);
      6'(ARP_OFF_PTYPE + 1): ok = (b == ARP_PTYPE_IPV4[7:0]);
      6'(ARP_OFF_HLEN):      ok = (b == ARP_HLEN_ETH);
      6'(ARP_OFF_PLEN):      ok = (b == ARP_PLEN_IPV4);
      6'(ARP_OFF_OPER):      ok = (b == ARP_OPER_REQ[15:8]);
      6'(ARP_OFF_OPER + 1):  ok = (b == ARP_OPER_REQ[7:0]) || (b == ARP_OPER_REP[7:0]);
      default:               ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/arp_rx_parser_if.sv
// Byte-serial receive stream from the Ethernet MAC. No backpressure:
// every beat with rx_valid high is consumed by the slave.
interface arp_rx_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;

  modport master (output rx_data, output rx_valid, output rx_last);
  modport slave  (input  rx_data, input  rx_valid, input  rx_last);
endinterface

// File: rtl/arp_rx_parser_stat_counter.sv
// Saturating event counter: increments on i_inc, holds at all-ones.
module stat_counter #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc,
  output logic [STAT_W-1:0] o_count
);

  logic [STAT_W-1:0] r_count;

  // Count events, never wrapping past all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {STAT_W{1'b1}})) begin
      r_count <= r_count + STAT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/arp_rx_parser.sv
// ARP receive parser: validates the Ethernet/ARP header byte by byte,
// captures SHA/SPA/TPA, and writes the sender IP/MAC pair into the
// IP-to-MAC cache with a one-cycle wea strobe.
// Optional build macro: ARP_RX_TARGET_FILTER_EN -- when defined, only
// frames targeting local_ip (or gratuitous frames, SPA == TPA) are learned.
module arp_rx_parser
  import toe_pkg::*;
#(
  parameter int LOCAL_IP_W = 32,
  parameter int STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  arp_rx_parser_if.slave        rx,
  input  logic [LOCAL_IP_W-1:0] local_ip,
  output logic [31:0]           ip_o,
  output logic [47:0]           mac_o,
  output logic                  wea,
  output logic                  is_request,
  output logic [STAT_W-1:0]     stat_learn,
  output logic [STAT_W-1:0]     stat_drop
);

  localparam logic [5:0] IDX_MAX = 6'd63;

  // Parse state.
  logic [5:0]  r_idx;
  logic        r_bad;
  logic [47:0] r_mac_sh;
  logic [31:0] r_ip_sh;
  logic [31:0] r_tpa_sh;
  logic        r_oper0;

  // FSM and registered cache-write outputs.
  arp_state_e  r_state;
  logic        r_wea;
  logic        r_req;
  logic [31:0] r_ip;
  logic [47:0] r_mac;

  logic        w_beat;
  logic        w_end;
  logic        w_bad_now;
  logic        w_in_sha;
  logic        w_in_spa;
  logic        w_in_tpa;
  logic [47:0] w_mac_next;
  logic [31:0] w_ip_next;
  logic [31:0] w_tpa_next;
  logic        w_oper0_next;
  logic        w_accept;
  logic        w_tpa_local;
  logic        w_filter_ok;
  logic        w_learn;
  logic        w_drop_inc;

  assign w_beat    = rx.rx_valid;
  assign w_end     = rx.rx_valid & rx.rx_last;
  assign w_bad_now = r_bad | (w_beat & ~hdr_byte_ok(r_idx, rx.rx_data));

  assign w_in_sha = (r_idx >= 6'(ARP_OFF_SHA)) && (r_idx < 6'(ARP_OFF_SHA + 6));
  assign w_in_spa = (r_idx >= 6'(ARP_OFF_SPA)) && (r_idx < 6'(ARP_OFF_SPA + 4));
  assign w_in_tpa = (r_idx >= 6'(ARP_OFF_TPA)) && (r_idx < 6'(ARP_OFF_TPA + 4));

  // Capture values including the current beat, so a frame whose last
  // byte is the final TPA byte can be judged on that same beat.
  always_comb begin
    w_mac_next   = r_mac_sh;
    w_ip_next    = r_ip_sh;
    w_tpa_next   = r_tpa_sh;
    w_oper0_next = r_oper0;
    if (w_beat && w_in_sha) w_mac_next = {r_mac_sh[39:0], rx.rx_data};
    if (w_beat && w_in_spa) w_ip_next  = {r_ip_sh[23:0], rx.rx_data};
    if (w_beat && w_in_tpa) w_tpa_next = {r_tpa_sh[23:0], rx.rx_data};
    if (w_beat && (r_idx == 6'(ARP_OFF_OPER + 1))) w_oper0_next = rx.rx_data[0];
  end

  assign w_accept    = w_end && (r_idx >= 6'(ARP_MIN_LEN - 1)) && !w_bad_now;
  assign w_tpa_local = (LOCAL_IP_W'(w_tpa_next) == local_ip);

`ifdef ARP_RX_TARGET_FILTER_EN
  assign w_filter_ok = w_tpa_local || (w_ip_next == w_tpa_next);
`else
  assign w_filter_ok = 1'b1;
`endif

  // Learn condition; sampled on the edge that enters COMMIT so wea is
  // already high during the COMMIT cycle.
  assign w_learn = w_accept && (w_ip_next != 32'd0) && !w_mac_next[40] && w_filter_ok;

  // Byte counter, sticky header error and field shift registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx    <= '0;
      r_bad    <= 1'b0;
      r_mac_sh <= '0;
      r_ip_sh  <= '0;
      r_tpa_sh <= '0;
      r_oper0  <= 1'b0;
    end else begin
      r_mac_sh <= w_mac_next;
      r_ip_sh  <= w_ip_next;
      r_tpa_sh <= w_tpa_next;
      r_oper0  <= w_oper0_next;
      if (w_end) begin
        r_idx <= '0;
        r_bad <= 1'b0;
      end else if (w_beat) begin
        if (r_idx != IDX_MAX) r_idx <= r_idx + 6'd1;
        r_bad <= w_bad_now;
      end
    end
  end

  // Frame-end FSM with registered cache-write outputs. Parsing keeps
  // running in COMMIT/DROP so a back-to-back frame loses no bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_wea   <= 1'b0;
      r_req   <= 1'b0;
      r_ip    <= '0;
      r_mac   <= '0;
    end else begin
      if (w_end) r_state <= w_accept ? ST_COMMIT : ST_DROP;
      else       r_state <= ST_RUN;
      r_wea <= w_learn;
      r_req <= w_learn && w_oper0_next && w_tpa_local;
      if (w_learn) begin
        r_ip  <= w_ip_next;
        r_mac <= w_mac_next;
      end
    end
  end

  // A well-formed frame that failed the learn condition counts as a drop.
  assign w_drop_inc = (r_state == ST_DROP) || ((r_state == ST_COMMIT) && !r_wea);

  stat_counter #(.STAT_W(STAT_W)) u_learn_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (r_wea),
    .o_count (stat_learn)
  );

  stat_counter #(.STAT_W(STAT_W)) u_drop_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_drop_inc),
    .o_count (stat_drop)
  );

  assign ip_o       = r_ip;
  assign mac_o      = r_mac;
  assign wea        = r_wea;
  assign is_request = r_req;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Bench for arp_rx_parser: table of directed frames, hand sequences for
// back-to-back and mid-frame reset, and random frames against a
// byte-array reference model. A second instance with 4-bit counters
// shares the stream so counter saturation is exercised.
`timescale 1ns/1ps
module tb_arp_rx_parser;

  localparam logic [31:0] LOCAL_IP = 32'h0ad68001;
`ifdef ARP_RX_TARGET_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  arp_rx_parser_if rx();

  logic [31:0] ip_o, s_ip;
  logic [47:0] mac_o, s_mac;
  logic        wea, is_request, s_wea, s_req;
  logic [15:0] stat_learn, stat_drop;
  logic [3:0]  s_learn, s_drop;

  arp_rx_parser #(.LOCAL_IP_W(32), .STAT_W(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .local_ip(LOCAL_IP),
    .ip_o(ip_o), .mac_o(mac_o), .wea(wea), .is_request(is_request),
    .stat_learn(stat_learn), .stat_drop(stat_drop)
  );

  arp_rx_parser #(.LOCAL_IP_W(32), .STAT_W(4)) u_sat (
    .clk(clk), .reset(reset), .rx(rx), .local_ip(LOCAL_IP),
    .ip_o(s_ip), .mac_o(s_mac), .wea(s_wea), .is_request(s_req),
    .stat_learn(s_learn), .stat_drop(s_drop)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_viol = 0;
  int sat_diff = 0;
  int last_cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] ip;
    logic [47:0] mac;
    logic        req;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  // Reference state.
  int          e_learn = 0;
  int          e_drop  = 0;
  logic [31:0] e_ip    = '0;
  logic [47:0] e_mac   = '0;

  logic [7:0] fr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every wea pulse; is_request must be low whenever wea is low.
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      ev_t e;
      e.cyc = cyc; e.ip = ip_o; e.mac = mac_o; e.req = is_request;
      obs_q.push_back(e);
    end else if (is_request !== 1'b0) begin
      req_viol++;
    end
    if ((s_wea !== wea) || (s_req !== is_request)) sat_diff++;
  end

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic build(input logic [15:0] etype, input logic [15:0] oper,
                       input logic [47:0] sha, input logic [31:0] spa,
                       input logic [31:0] tpa, input int len);
    logic [7:0] b [0:41];
    for (int i = 0; i < 6; i++) begin
      b[i]      = 8'hff;
      b[6 + i]  = sha[47 - 8*i -: 8];
      b[22 + i] = sha[47 - 8*i -: 8];
      b[32 + i] = 8'h00;
    end
    b[12] = etype[15:8]; b[13] = etype[7:0];
    b[14] = 8'h00; b[15] = 8'h01; b[16] = 8'h08; b[17] = 8'h00;
    b[18] = 8'd6;  b[19] = 8'd4;
    b[20] = oper[15:8]; b[21] = oper[7:0];
    for (int i = 0; i < 4; i++) begin
      b[28 + i] = spa[31 - 8*i -: 8];
      b[38 + i] = tpa[31 - 8*i -: 8];
    end
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back((i < 42) ? b[i] : 8'($urandom));
  endtask

  // Reference: judge the whole frame from its byte image.
  function automatic bit model(output logic [31:0] ip, output logic [47:0] mac, output bit req);
    bit ok;
    logic [31:0] tpa;
    logic [15:0] oper;
    ip = '0; mac = '0; req = 1'b0;
    if (fr.size() < 42) return 1'b0;
    oper = {fr[20], fr[21]};
    ok = ({fr[12], fr[13]} == 16'h0806) && ({fr[14], fr[15]} == 16'h0001) &&
         ({fr[16], fr[17]} == 16'h0800) && (fr[18] == 8'd6) && (fr[19] == 8'd4) &&
         ((oper == 16'd1) || (oper == 16'd2));
    mac = {fr[22], fr[23], fr[24], fr[25], fr[26], fr[27]};
    ip  = {fr[28], fr[29], fr[30], fr[31]};
    tpa = {fr[38], fr[39], fr[40], fr[41]};
    req = (oper == 16'd1) && (tpa == LOCAL_IP);
    if (FILT && (tpa != LOCAL_IP) && (ip != tpa)) ok = 1'b0;
    return ok && (ip != 32'd0) && !mac[40];
  endfunction

  task automatic expect_frame(input bit learn, input logic [31:0] ip,
                              input logic [47:0] mac, input bit req);
    ev_t e;
    if (learn) begin
      e.cyc = last_cyc + 1; e.ip = ip; e.mac = mac; e.req = req;
      exp_q.push_back(e);
      e_learn++; e_ip = ip; e_mac = mac;
    end else begin
      e_drop++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx.rx_valid = 1'b0; rx.rx_last = 1'b0; rx.rx_data = 8'($urandom);
    end
  endtask

  // Drive fr; idle_pct inserts random invalid beats (with junk rx_last).
  task automatic send(input int idle_pct);
    for (int i = 0; i < fr.size(); i++) begin
      while ((idle_pct > 0) && ($urandom_range(99, 0) < idle_pct)) begin
        @(negedge clk);
        rx.rx_valid = 1'b0; rx.rx_data = 8'($urandom); rx.rx_last = 1'($urandom);
      end
      @(negedge clk);
      rx.rx_valid = 1'b1; rx.rx_data = fr[i]; rx.rx_last = (i == fr.size() - 1);
      last_cyc = cyc;
    end
  endtask

  task automatic send_model(input int idle_pct);
    logic [31:0] ip; logic [47:0] mac; bit req; bit l;
    send(idle_pct);
    l = model(ip, mac, req);
    expect_frame(l, ip, mac, req);
  endtask

  task automatic check_all(input string tag);
    int n;
    idle(3);
    chk({tag, "_wea_count"}, obs_q.size(), exp_q.size());
    n = min2(obs_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      chk({tag, "_wea_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_ip_o"},      obs_q[i].ip,  exp_q[i].ip);
      chk({tag, "_mac_o"},     obs_q[i].mac, exp_q[i].mac);
      chk({tag, "_is_request"}, obs_q[i].req, exp_q[i].req);
    end
    obs_q.delete(); exp_q.delete();
    chk({tag, "_stat_learn"}, stat_learn, e_learn);
    chk({tag, "_stat_drop"},  stat_drop,  e_drop);
    chk({tag, "_ip_hold"},    ip_o,  e_ip);
    chk({tag, "_mac_hold"},   mac_o, e_mac);
    chk({tag, "_sat_learn"},  s_learn, min2(e_learn, 15));
    chk({tag, "_sat_drop"},   s_drop,  min2(e_drop, 15));
    chk({tag, "_req_without_wea"}, req_viol, 0);
    chk({tag, "_sat_inst_agree"}, sat_diff, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wea"}, wea, 1'b0);
    chk({tag, "_is_request"}, is_request, 1'b0);
    chk({tag, "_ip_o"}, ip_o, 32'd0);
    chk({tag, "_mac_o"}, mac_o, 48'd0);
    chk({tag, "_stat_learn"}, stat_learn, 16'd0);
    chk({tag, "_stat_drop"}, stat_drop, 16'd0);
  endtask

  typedef struct {
    logic [15:0] etype;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    int          len;
    bit          wea_nf;   // learned with the target filter off
    bit          wea_f;    // learned with the target filter on
    bit          req;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{16'h0806, 16'h0001, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP,      60, 1, 1, 1};
    vt[1]  = '{16'h0800, 16'h0001, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP,      60, 0, 0, 0};
    vt[2]  = '{16'h0806, 16'h0001, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP,      31, 0, 0, 0};
    vt[3]  = '{16'h0806, 16'h0001, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP,      60, 1, 1, 1};
    vt[4]  = '{16'h0806, 16'h0002, 48'h9cebe822fd19, 32'h0bd680ea, LOCAL_IP,      42, 1, 1, 0};
    vt[5]  = '{16'h0806, 16'h0001, 48'h9cebe822fd18, 32'h00000000, LOCAL_IP,      60, 0, 0, 0};
    vt[6]  = '{16'h0806, 16'h0001, 48'h9cebe822fd18, 32'h0ad680ea, 32'h0ad68099, 60, 1, 0, 0};
    vt[7]  = '{16'h0806, 16'h0001, 48'h020000000001, 32'h0ad68055, 32'h0ad68055, 42, 1, 1, 0};
    vt[8]  = '{16'h0806, 16'h0001, 48'h01005e000001, 32'h0ad680ea, LOCAL_IP,      60, 0, 0, 0};
    vt[9]  = '{16'h0806, 16'h0003, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP,      60, 0, 0, 0};
    vt[10] = '{16'h0806, 16'h0101, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP,      60, 0, 0, 0};
    vt[11] = '{16'h0806, 16'h0002, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP,      41, 0, 0, 0};
    vt[12] = '{16'h0806, 16'h0002, 48'h001122334455, 32'hc0a80001, LOCAL_IP,      70, 1, 1, 0};

    rx.rx_valid = 1'b0; rx.rx_last = 1'b0; rx.rx_data = 8'h00;
    #2 reset = 1'b0;
    idle(3);
    chk_reset_state("reset");
    reset = 1'b1;
    idle(2);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      bit l;
      build(vt[i].etype, vt[i].oper, vt[i].sha, vt[i].spa, vt[i].tpa, vt[i].len);
      send(0);
      l = FILT ? vt[i].wea_f : vt[i].wea_nf;
      expect_frame(l, vt[i].spa, vt[i].sha, vt[i].req && l);
      check_all($sformatf("vec%0d", i));
    end

    // Two replies with zero idle between them.
    build(16'h0806, 16'h0002, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP, 42);
    send(0);
    expect_frame(1'b1, 32'h0ad680ea, 48'h9cebe822fd18, 1'b0);
    build(16'h0806, 16'h0002, 48'h9cebe822fd19, 32'h0bd680ea, LOCAL_IP, 42);
    send(0);
    expect_frame(1'b1, 32'h0bd680ea, 48'h9cebe822fd19, 1'b0);
    check_all("b2b");

    // Good frame, one-byte runt during COMMIT, good frame, no gaps.
    build(16'h0806, 16'h0001, 48'h9cebe822fd20, 32'h0ad68101, LOCAL_IP, 42);
    send_model(0);
    build(16'h0806, 16'h0001, 48'h9cebe822fd21, 32'h0ad68102, LOCAL_IP, 1);
    send_model(0);
    build(16'h0806, 16'h0002, 48'h9cebe822fd22, 32'h0ad68103, LOCAL_IP, 44);
    send_model(0);
    check_all("runt_in_commit");

    // Random frames against the reference model.
    for (int f = 0; f < 160; f++) begin
      logic [15:0] et, op;
      logic [47:0] sha;
      logic [31:0] spa, tpa;
      int len, r;
      et  = ($urandom_range(9, 0) == 0) ? 16'h0800 : 16'h0806;
      r   = $urandom_range(4, 0);
      op  = (r < 2) ? 16'd1 : (r < 4) ? 16'd2 : 16'd3;
      sha = {16'($urandom), 32'($urandom)};
      if ($urandom_range(4, 0) != 0) sha[40] = 1'b0;
      spa = ($urandom_range(9, 0) == 0) ? 32'd0 : 32'($urandom);
      r   = $urandom_range(9, 0);
      tpa = (r < 5) ? LOCAL_IP : (r < 7) ? spa : 32'($urandom);
      len = ($urandom_range(4, 0) == 0) ? $urandom_range(41, 1) : $urandom_range(70, 42);
      build(et, op, sha, spa, tpa, len);
      send_model(($urandom_range(1, 0) == 0) ? 0 : 20);
      idle($urandom_range(2, 0));
      if ((f % 10) == 9) check_all($sformatf("rand%0d", f));
    end

    // Reset at byte 25 of a valid frame, then one full frame.
    build(16'h0806, 16'h0001, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP, 60);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rx.rx_valid = 1'b1; rx.rx_data = fr[i]; rx.rx_last = 1'b0;
    end
    @(negedge clk);
    rx.rx_valid = 1'b0;
    reset = 1'b0;
    e_learn = 0; e_drop = 0; e_ip = '0; e_mac = '0;
    idle(2);
    chk_reset_state("midreset");
    reset = 1'b1;
    idle(1);
    build(16'h0806, 16'h0002, 48'h9cebe822fd30, 32'h0ad680f0, LOCAL_IP, 60);
    send(0);
    expect_frame(1'b1, 32'h0ad680f0, 48'h9cebe822fd30, 1'b0);
    check_all("post_reset");

    // Drive the 4-bit drop counter past saturation with one-byte runts.
    for (int i = 0; i < 20; i++) begin
      build(16'h0806, 16'h0001, 48'h9cebe822fd18, 32'h0ad680ea, LOCAL_IP, 1);
      send_model(0);
    end
    check_all("saturate");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
